saturn_bus_arbiter: RTL
=======================

# saturn_bus_arbiter

Shares the single 4-phase Saturn nibble bus between two requesters: the control unit's bus program stream (port 0) and the debugger's memory-access stream (port 1). Each requester presents a locked transaction: a sequence of write (CMD/DATA) and read entries terminated by a `last` flag. The arbiter grants ownership per transaction with round-robin fairness, issues one entry per bus cycle in the phase-1 slot, and returns read nibbles captured in the phase-2 slot. It sits between the requesters and the bus pins (`o_bus_*`/`i_bus_nibble_in`), replacing direct bus driving by the bus controller.

## Interface
- `TIMEOUT`, default 8: bus cycles an owner may hold the grant with `req` low before forced release.
- `i_clk`  in  1  system clock
- `i_reset`  in  1  synchronous, active-high
- `i_clk_en`  in  1  bus-cycle enable; all state advances only when high
- `i_phases`  in  4  one-hot phase (0001, 0010, 0100, 1000)
- `i_rN_req`  in  1  (N=0,1) entry valid
- `i_rN_rd`  in  1  entry is a read slot; `i_rN_data` ignored
- `i_rN_data`  in  5  bit4=1 CMD, 0 DATA; [3:0] nibble
- `i_rN_last`  in  1  entry ends the transaction
- `o_rN_ack`  out  1  one-i_clk pulse: entry consumed
- `o_rN_rdata`  out  4  captured read nibble
- `o_rN_rvalid`  out  1  one-i_clk pulse: `o_rN_rdata` valid
- `o_grant`  out  2  one-hot current owner; 00 = idle
- `o_error`  out  1  one-i_clk pulse on timeout release
- `o_bus_clk_en`  out  1  bus strobe
- `o_bus_is_data`  out  1  1 = DATA / read, 0 = CMD
- `o_bus_nibble_out`  out  4  nibble driven to bus
- `i_bus_nibble_in`  in  4  nibble from bus

## Operation
- States: IDLE (grant 00), OWN0, OWN1. Round-robin pointer `last_owner`; reset value 1, so port 0 wins the first tie.
- Phase 0001 in IDLE: if any `req`, select winner. If only one requester, it wins. If both, the winner is the port ≠ `last_owner`. Enter OWNw and issue the winner's entry in the same phase.
- Phase 0001 in OWNw with `i_rw_req`=1: issue entry.
  - Write entry: `o_bus_is_data` ← !data[4], `o_bus_nibble_out` ← data[3:0], `o_bus_clk_en` ← 1.
  - Read entry: `o_bus_is_data` ← 1, `o_bus_nibble_out` held, `o_bus_clk_en` ← 1, read-pending ← 1.
  - `o_rw_ack` pulses. Entry's `last` is latched in release-pending. Idle counter ← 0.
- Phase 0001 in OWNw with `req`=0: nothing issued; idle counter += 1. The other requester cannot preempt.
- Phase 0010: `o_bus_clk_en` ← 0. If read-pending: `o_rw_rdata` ← `i_bus_nibble_in`, `o_rw_rvalid` pulses, read-pending ← 0.
- Phase 0100: no action.
- Phase 1000:
  - If release-pending: go to IDLE and set `last_owner` ← w.
  - Else if idle counter == TIMEOUT: go to IDLE, set `last_owner` ← w, and pulse `o_error`.
- Idle counter is saturating, width clog2(TIMEOUT+1).

## Timing
- Issue latency: a `req` seen at the phase-0001 enabled edge drives the bus on the next i_clk. There is no extra arbitration cycle.
- `o_rN_ack`, `o_rN_rvalid`, `o_error` are high for exactly one i_clk cycle, then cleared on the next edge regardless of `i_clk_en`.
- The requester must present its next entry before the next phase-0001 enabled edge. Holding `req` across ack is treated as a new entry.
- Throughput: one entry per 4 enabled cycles. Back-to-back transactions from alternating ports lose no bus cycle.
- A non-owner's `req` is never acked while another port owns the bus.
- Reset values:
  - All outputs 0.
  - Grant 00, state IDLE, read-pending 0, release-pending 0, idle counter 0, `last_owner` 1.
- Reset mid-transaction aborts it: no ack, no rvalid. The bus strobe drops on the next i_clk.
- `i_clk_en`=0 freezes all state; pending pulses still clear.

## Test plan
- Port 0 alone sends CMD 4, DATA A, DATA 5 (last): bus shows is_data 0/1/1 with nibbles 4/A/5 on three successive phase-1 slots. Three `o_r0_ack` pulses, then `o_grant` 01→00 at phase 1000.
- Both ports request in IDLE after reset: port 0 is granted. Its transaction finishes, port 1 is granted on the very next phase-1 slot. A following tie goes to port 0.
- Port 1 read entry with bus returning 7: `o_bus_clk_en`=1 in phase 1, `o_r1_rdata`=7 with `o_r1_rvalid` pulse after phase 2.
- Port 0 granted, then `req` low for 8 bus cycles with port 1 requesting: `o_error` pulses, grant goes to 00 and then to port 1. Port 1 is never acked before the release.
- `i_clk_en` gated low for 5 cycles mid-transaction: outputs and grant hold, no duplicate ack. Reset asserted while a read is pending: all outputs 0 next cycle, no rvalid.

Source files
------------

// File: rtl/saturn_bus_arbiter.sv
// rtl/saturn_bus_arbiter.sv - two-port round-robin owner of the 4-phase Saturn nibble bus
module saturn_bus_arbiter #(
  parameter int TIMEOUT = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clk_en,
  input  logic [3:0] i_phases,
  input  logic       i_r0_req,
  input  logic       i_r0_rd,
  input  logic [4:0] i_r0_data,
  input  logic       i_r0_last,
  output logic       o_r0_ack,
  output logic [3:0] o_r0_rdata,
  output logic       o_r0_rvalid,
  input  logic       i_r1_req,
  input  logic       i_r1_rd,
  input  logic [4:0] i_r1_data,
  input  logic       i_r1_last,
  output logic       o_r1_ack,
  output logic [3:0] o_r1_rdata,
  output logic       o_r1_rvalid,
  output logic [1:0] o_grant,
  output logic       o_error,
  output logic       o_bus_clk_en,
  output logic       o_bus_is_data,
  output logic [3:0] o_bus_nibble_out,
  input  logic [3:0] i_bus_nibble_in
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t        state_q, state_d;
  logic          last_owner_q, last_owner_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rel_pend_q, rel_pend_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic          bus_clk_en_q, bus_clk_en_d;
  logic          bus_is_data_q, bus_is_data_d;
  logic [3:0]    bus_nib_q, bus_nib_d;
  logic [1:0]    ack_q, ack_d;
  logic [1:0]    rvalid_q, rvalid_d;
  logic [3:0]    rdata0_q, rdata0_d;
  logic [3:0]    rdata1_q, rdata1_d;
  logic          error_q, error_d;
  logic          issue;
  logic          port;
  logic          sel_rd;
  logic [4:0]    sel_data;
  logic          sel_last;

  // Arbitration, entry issue, read capture and release decisions; only enabled cycles move state,
  // while the one-cycle pulses fall back to zero on every clock.
  always_comb begin
    state_d       = state_q;
    last_owner_d  = last_owner_q;
    rd_pend_d     = rd_pend_q;
    rel_pend_d    = rel_pend_q;
    idle_cnt_d    = idle_cnt_q;
    bus_clk_en_d  = bus_clk_en_q;
    bus_is_data_d = bus_is_data_q;
    bus_nib_d     = bus_nib_q;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    ack_d         = 2'b00;
    rvalid_d      = 2'b00;
    error_d       = 1'b0;
    issue         = 1'b0;
    port          = (state_q == OWN1);
    sel_rd        = 1'b0;
    sel_data      = 5'd0;
    sel_last      = 1'b0;
    if (i_clk_en) begin
      case (i_phases)
        4'b0001: begin
          if (state_q == IDLE) begin
            if (i_r0_req || i_r1_req) begin
              issue   = 1'b1;
              port    = (i_r0_req && i_r1_req) ? ~last_owner_q : i_r1_req;
              state_d = port ? OWN1 : OWN0;
            end
          end else if (port ? i_r1_req : i_r0_req) begin
            issue = 1'b1;
          end else if (idle_cnt_q != TO_MAX) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
          if (issue) begin
            sel_rd       = port ? i_r1_rd : i_r0_rd;
            sel_data     = port ? i_r1_data : i_r0_data;
            sel_last     = port ? i_r1_last : i_r0_last;
            ack_d        = port ? 2'b10 : 2'b01;
            rel_pend_d   = sel_last;
            idle_cnt_d   = '0;
            bus_clk_en_d = 1'b1;
            if (sel_rd) begin
              bus_is_data_d = 1'b1;
              rd_pend_d     = 1'b1;
            end else begin
              bus_is_data_d = ~sel_data[4];
              bus_nib_d     = sel_data[3:0];
            end
          end
        end
        4'b0010: begin
          bus_clk_en_d = 1'b0;
          if (rd_pend_q) begin
            rd_pend_d = 1'b0;
            if (port) begin
              rdata1_d    = i_bus_nibble_in;
              rvalid_d[1] = 1'b1;
            end else begin
              rdata0_d    = i_bus_nibble_in;
              rvalid_d[0] = 1'b1;
            end
          end
        end
        4'b1000: begin
          if (state_q != IDLE) begin
            if (rel_pend_q) begin
              state_d      = IDLE;
              last_owner_d = port;
              rel_pend_d   = 1'b0;
              idle_cnt_d   = '0;
            end else if (idle_cnt_q == TO_MAX) begin
              state_d      = IDLE;
              last_owner_d = port;
              idle_cnt_d   = '0;
              error_d      = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State register with synchronous active-high reset; reset also aborts any in-flight entry.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= IDLE;
      last_owner_q  <= 1'b1;
      rd_pend_q     <= 1'b0;
      rel_pend_q    <= 1'b0;
      idle_cnt_q    <= '0;
      bus_clk_en_q  <= 1'b0;
      bus_is_data_q <= 1'b0;
      bus_nib_q     <= 4'd0;
      ack_q         <= 2'b00;
      rvalid_q      <= 2'b00;
      rdata0_q      <= 4'd0;
      rdata1_q      <= 4'd0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_owner_q  <= last_owner_d;
      rd_pend_q     <= rd_pend_d;
      rel_pend_q    <= rel_pend_d;
      idle_cnt_q    <= idle_cnt_d;
      bus_clk_en_q  <= bus_clk_en_d;
      bus_is_data_q <= bus_is_data_d;
      bus_nib_q     <= bus_nib_d;
      ack_q         <= ack_d;
      rvalid_q      <= rvalid_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
      error_q       <= error_d;
    end
  end

  assign o_grant          = {state_q == OWN1, state_q == OWN0};
  assign o_r0_ack         = ack_q[0];
  assign o_r1_ack         = ack_q[1];
  assign o_r0_rvalid      = rvalid_q[0];
  assign o_r1_rvalid      = rvalid_q[1];
  assign o_r0_rdata       = rdata0_q;
  assign o_r1_rdata       = rdata1_q;
  assign o_error          = error_q;
  assign o_bus_clk_en     = bus_clk_en_q;
  assign o_bus_is_data    = bus_is_data_q;
  assign o_bus_nibble_out = bus_nib_q;

endmodule
